// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and default widths for the dmem block mover
package dmem_pkg;

    localparam int ABITS = 32;
    localparam int DBITS = 32;
    localparam int LBITS = 8;

    typedef enum logic {
        MODE_COPY = 1'b0,
        MODE_FILL = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_addr_ptr.sv
// rtl/dmem_addr_ptr.sv - loadable wrapping word-address incrementer
// Ports: clock, reset_n (async, active low); load/load_value set the pointer,
// inc advances it by one modulo 2^Abits; value is the current pointer.
module dmem_addr_ptr
    import dmem_pkg::*;
#(
    parameter int Abits = ABITS
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [Abits-1:0] load_value,
    input  logic             inc,
    output logic [Abits-1:0] value
);

    logic [Abits-1:0] value_q;
    logic [Abits-1:0] value_d;

    // Load wins over inc; the add wraps naturally at the register width.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_value;
        end else if (inc) begin
            value_d = value_q + Abits'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/dmem_block_mover.sv
// rtl/dmem_block_mover.sv - block COPY/FILL initiator on the data memory port
// Ports: start/mode/src_addr/dst_addr/length/fill_data request a transfer;
// busy/done/words_done report progress; mem_wr/mem_addr/mem_writedata drive
// dmem and mem_readdata returns combinational read data.
module dmem_block_mover
    import dmem_pkg::*;
#(
    parameter int Abits = ABITS,
    parameter int Dbits = DBITS,
    parameter int Lbits = LBITS
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mode,
    input  logic [Abits-1:0] src_addr,
    input  logic [Abits-1:0] dst_addr,
    input  logic [Lbits-1:0] length,
    input  logic [Dbits-1:0] fill_data,
    output logic             busy,
    output logic             done,
    output logic [Lbits-1:0] words_done,
    output logic             mem_wr,
    output logic [Abits-1:0] mem_addr,
    output logic [Dbits-1:0] mem_writedata,
    input  logic [Dbits-1:0] mem_readdata
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [Dbits-1:0] fill_q, fill_d;
    logic [Dbits-1:0] hold_q, hold_d;
    logic [Lbits-1:0] remaining_q, remaining_d;
    logic [Lbits-1:0] words_done_q, words_done_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             src_load, src_inc;
    logic             dst_load, dst_inc;
    logic [Abits-1:0] src_ptr, dst_ptr;

    dmem_addr_ptr #(.Abits(Abits)) u_src_ptr (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (src_load),
        .load_value (src_addr),
        .inc        (src_inc),
        .value      (src_ptr)
    );

    dmem_addr_ptr #(.Abits(Abits)) u_dst_ptr (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (dst_load),
        .load_value (dst_addr),
        .inc        (dst_inc),
        .value      (dst_ptr)
    );

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        fill_d       = fill_q;
        hold_d       = hold_q;
        remaining_d  = remaining_q;
        words_done_d = words_done_q;
        done_d       = 1'b0;
        src_load     = 1'b0;
        src_inc      = 1'b0;
        dst_load     = 1'b0;
        dst_inc      = 1'b0;

        case (state_q)
            IDLE: begin
                // Accepted in the done cycle too, since the FSM is already IDLE.
                if (start) begin
                    mode_d       = mode_e'(mode);
                    fill_d       = fill_data;
                    remaining_d  = length;
                    words_done_d = '0;
                    src_load     = 1'b1;
                    dst_load     = 1'b1;
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else if (mode_e'(mode) == MODE_FILL) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                hold_d  = mem_readdata;
                src_inc = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                dst_inc      = 1'b1;
                remaining_d  = remaining_q - Lbits'(1);
                words_done_d = words_done_q + Lbits'(1);
                if (remaining_q == Lbits'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (mode_q == MODE_FILL) begin
                    state_d = WRITE;
                end else begin
                    state_d = READ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            mode_q       <= MODE_COPY;
            fill_q       <= '0;
            hold_q       <= '0;
            remaining_q  <= '0;
            words_done_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            fill_q       <= fill_d;
            hold_q       <= hold_d;
            remaining_q  <= remaining_d;
            words_done_q <= words_done_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Bus outputs decode straight from the state register so that an async
    // reset drops mem_wr immediately and IDLE always presents zeros.
    always_comb begin
        mem_wr        = 1'b0;
        mem_addr      = '0;
        mem_writedata = '0;
        case (state_q)
            READ: begin
                mem_addr = src_ptr;
            end
            WRITE: begin
                mem_wr        = 1'b1;
                mem_addr      = dst_ptr;
                mem_writedata = (mode_q == MODE_FILL) ? fill_q : hold_q;
            end
            default: begin
                mem_wr = 1'b0;
            end
        endcase
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign words_done = words_done_q;

endmodule

// File: tb/tb_dmem_block_mover.sv
// tb/tb_dmem_block_mover.sv - directed self-checking bench for dmem_block_mover
module tb_dmem_block_mover;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        mode;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [7:0]  length;
    logic [31:0] fill_data;
    logic        busy;
    logic        done;
    logic [7:0]  words_done;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    logic [31:0] mem [0:63];
    logic        tb_we;
    logic [5:0]  tb_waddr;
    logic [31:0] tb_wdata;

    int total;
    int bad;

    dmem_block_mover dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .mode          (mode),
        .src_addr      (src_addr),
        .dst_addr      (dst_addr),
        .length        (length),
        .fill_data     (fill_data),
        .busy          (busy),
        .done          (done),
        .words_done    (words_done),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_readdata = mem[mem_addr[5:0]];

    always @(posedge clock) begin
        if (mem_wr) begin
            mem[mem_addr[5:0]] <= mem_writedata;
        end else if (tb_we) begin
            mem[tb_waddr] <= tb_wdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        @(posedge clock);
        #1;
        tb_we    = 1'b1;
        tb_waddr = a;
        tb_wdata = d;
        @(posedge clock);
        #1;
        tb_we = 1'b0;
    endtask

    // Start edge is the posedge after the request is raised; returns 1ns after it.
    task automatic do_start(input logic m, input logic [31:0] s, input logic [31:0] d,
                            input logic [7:0] len, input logic [31:0] f);
        @(posedge clock);
        #1;
        start     = 1'b1;
        mode      = m;
        src_addr  = s;
        dst_addr  = d;
        length    = len;
        fill_data = f;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy actual=%0b required=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done actual=%0b required=0", done); end
        total++; if (words_done !== 8'd0) begin bad++; $display("FAIL reset_words_done actual=%0d required=0", words_done); end
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL reset_mem_wr actual=%0b required=0", mem_wr); end
        total++; if (mem_addr !== 32'd0) begin bad++; $display("FAIL reset_mem_addr actual=%h required=0", mem_addr); end
        total++; if (mem_writedata !== 32'd0) begin bad++; $display("FAIL reset_mem_writedata actual=%h required=0", mem_writedata); end
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_copy;
        logic [31:0] exp_data [0:3];
        exp_data[0] = 32'hAAAA_0001;
        exp_data[1] = 32'hBBBB_0002;
        exp_data[2] = 32'hCCCC_0003;
        exp_data[3] = 32'hDDDD_0004;
        for (int i = 0; i < 4; i++) preload(6'(4 + i), exp_data[i]);
        do_start(1'b0, 32'd4, 32'd16, 8'd4, 32'h0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            total++;
            if (mem_wr !== ((k % 2 == 0) && k <= 8)) begin
                bad++; $display("FAIL copy_wr cycle=%0d actual=%0b required=%0b", k, mem_wr, (k % 2 == 0) && k <= 8);
            end
            if ((k % 2 == 0) && k <= 8) begin
                total++;
                if (mem_addr !== 32'(16 + k / 2 - 1)) begin
                    bad++; $display("FAIL copy_addr cycle=%0d actual=%0d required=%0d", k, mem_addr, 16 + k / 2 - 1);
                end
                total++;
                if (mem_writedata !== exp_data[k / 2 - 1]) begin
                    bad++; $display("FAIL copy_data cycle=%0d actual=%h required=%h", k, mem_writedata, exp_data[k / 2 - 1]);
                end
            end
            total++;
            if (done !== (k == 9)) begin bad++; $display("FAIL copy_done cycle=%0d actual=%0b required=%0b", k, done, k == 9); end
            total++;
            if (busy !== (k <= 8)) begin bad++; $display("FAIL copy_busy cycle=%0d actual=%0b required=%0b", k, busy, k <= 8); end
        end
        total++; if (words_done !== 8'd4) begin bad++; $display("FAIL copy_words_done actual=%0d required=4", words_done); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[16 + i] !== exp_data[i]) begin bad++; $display("FAIL copy_mem idx=%0d actual=%h required=%h", 16 + i, mem[16 + i], exp_data[i]); end
        end
    endtask

    task automatic test_fill;
        int busy_cycles;
        busy_cycles = 0;
        do_start(1'b1, 32'd0, 32'd8, 8'd3, 32'hDEAD_BEEF);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (busy === 1'b1) busy_cycles++;
            total++;
            if (mem_wr !== (k <= 3)) begin bad++; $display("FAIL fill_wr cycle=%0d actual=%0b required=%0b", k, mem_wr, k <= 3); end
            if (k <= 3) begin
                total++;
                if (mem_addr !== 32'(8 + k - 1)) begin bad++; $display("FAIL fill_addr cycle=%0d actual=%0d required=%0d", k, mem_addr, 8 + k - 1); end
                total++;
                if (mem_writedata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fill_data cycle=%0d actual=%h required=deadbeef", k, mem_writedata); end
            end
            total++;
            if (done !== (k == 4)) begin bad++; $display("FAIL fill_done cycle=%0d actual=%0b required=%0b", k, done, k == 4); end
        end
        total++; if (busy_cycles != 3) begin bad++; $display("FAIL fill_busy_cycles actual=%0d required=3", busy_cycles); end
        total++; if (words_done !== 8'd3) begin bad++; $display("FAIL fill_words_done actual=%0d required=3", words_done); end
    endtask

    task automatic test_zero_length;
        do_start(1'b1, 32'd0, 32'd12, 8'd0, 32'h1111_1111);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL zero_wr cycle=%0d actual=%0b required=0", k, mem_wr); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy cycle=%0d actual=%0b required=0", k, busy); end
            total++; if (done !== (k == 1)) begin bad++; $display("FAIL zero_done cycle=%0d actual=%0b required=%0b", k, done, k == 1); end
        end
        total++; if (words_done !== 8'd0) begin bad++; $display("FAIL zero_words_done actual=%0d required=0", words_done); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_data [0:3];
        exp_data[0] = 32'hAAAA_0001;
        exp_data[1] = 32'hBBBB_0002;
        exp_data[2] = 32'hCCCC_0003;
        exp_data[3] = 32'hDDDD_0004;
        do_start(1'b0, 32'd4, 32'd32, 8'd4, 32'h0);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clock);
            if (k == 3) begin
                start = 1'b1; mode = 1'b1; src_addr = 32'd0; dst_addr = 32'd40; length = 8'd2; fill_data = 32'h9999_9999;
            end else if (k == 9) begin
                start = 1'b1; mode = 1'b1; src_addr = 32'd0; dst_addr = 32'd48; length = 8'd1; fill_data = 32'h1234_5678;
            end else begin
                start = 1'b0;
            end
            if (k <= 9) begin
                total++;
                if (mem_wr !== ((k % 2 == 0) && k <= 8)) begin
                    bad++; $display("FAIL b2b_wr cycle=%0d actual=%0b required=%0b", k, mem_wr, (k % 2 == 0) && k <= 8);
                end
                if ((k % 2 == 0) && k <= 8) begin
                    total++;
                    if (mem_addr !== 32'(32 + k / 2 - 1)) begin bad++; $display("FAIL b2b_addr cycle=%0d actual=%0d required=%0d", k, mem_addr, 32 + k / 2 - 1); end
                    total++;
                    if (mem_writedata !== exp_data[k / 2 - 1]) begin bad++; $display("FAIL b2b_data cycle=%0d actual=%h required=%h", k, mem_writedata, exp_data[k / 2 - 1]); end
                end
                total++;
                if (done !== (k == 9)) begin bad++; $display("FAIL b2b_done cycle=%0d actual=%0b required=%0b", k, done, k == 9); end
            end else if (k == 10) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_restart_busy actual=%0b required=1", busy); end
                total++; if (mem_wr !== 1'b1) begin bad++; $display("FAIL b2b_restart_wr actual=%0b required=1", mem_wr); end
                total++; if (mem_addr !== 32'd48) begin bad++; $display("FAIL b2b_restart_addr actual=%0d required=48", mem_addr); end
                total++; if (mem_writedata !== 32'h1234_5678) begin bad++; $display("FAIL b2b_restart_data actual=%h required=12345678", mem_writedata); end
            end else begin
                total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_restart_done actual=%0b required=1", done); end
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_restart_idle actual=%0b required=0", busy); end
            end
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[32 + i] !== exp_data[i]) begin bad++; $display("FAIL b2b_mem idx=%0d actual=%h required=%h", 32 + i, mem[32 + i], exp_data[i]); end
        end
        total++; if (mem[40] === 32'h9999_9999) begin bad++; $display("FAIL b2b_ignored_start actual=%h required=not 99999999", mem[40]); end
    endtask

    task automatic test_wrap;
        do_start(1'b1, 32'd0, 32'hFFFF_FFFF, 8'd2, 32'h0000_0055);
        @(negedge clock);
        total++; if (mem_wr !== 1'b1) begin bad++; $display("FAIL wrap_wr0 actual=%0b required=1", mem_wr); end
        total++; if (mem_addr !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_addr0 actual=%h required=ffffffff", mem_addr); end
        @(negedge clock);
        total++; if (mem_wr !== 1'b1) begin bad++; $display("FAIL wrap_wr1 actual=%0b required=1", mem_wr); end
        total++; if (mem_addr !== 32'h0000_0000) begin bad++; $display("FAIL wrap_addr1 actual=%h required=00000000", mem_addr); end
        @(negedge clock);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL wrap_done actual=%0b required=1", done); end
    endtask

    task automatic test_reset_mid;
        do_start(1'b0, 32'd4, 32'd20, 8'd8, 32'h0);
        repeat (4) @(negedge clock);
        total++; if (mem_wr !== 1'b1) begin bad++; $display("FAIL mid_pre_wr actual=%0b required=1", mem_wr); end
        reset_n = 1'b0;
        #1;
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL mid_wr actual=%0b required=0", mem_wr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy actual=%0b required=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_done actual=%0b required=0", done); end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_after_busy actual=%0b required=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_after_done actual=%0b required=0", done); end
        total++; if (words_done !== 8'd0) begin bad++; $display("FAIL mid_after_words_done actual=%0d required=0", words_done); end
        do_start(1'b1, 32'd0, 32'd60, 8'd1, 32'h0000_0077);
        @(negedge clock);
        total++; if (mem_wr !== 1'b1 || mem_addr !== 32'd60) begin bad++; $display("FAIL mid_fresh_write actual=%0b@%0d required=1@60", mem_wr, mem_addr); end
        @(negedge clock);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL mid_fresh_done actual=%0b required=1", done); end
        total++; if (words_done !== 8'd1) begin bad++; $display("FAIL mid_fresh_words_done actual=%0d required=1", words_done); end
        total++; if (mem[60] !== 32'h0000_0077) begin bad++; $display("FAIL mid_fresh_mem actual=%h required=00000077", mem[60]); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        start     = 1'b0;
        mode      = 1'b0;
        src_addr  = '0;
        dst_addr  = '0;
        length    = '0;
        fill_data = '0;
        tb_we     = 1'b0;
        tb_waddr  = '0;
        tb_wdata  = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        test_reset;
        test_copy;
        test_fill;
        test_zero_length;
        test_back_to_back;
        test_wrap;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
